controle_soma16: RTL
====================

Name: controle_soma16

Overview:
- Multi-cycle controller that sequences one 4-bit adder slice to perform 16-bit add/subtract, one nibble per clock, LSB first.
- Saves area versus a full-width adder; intended as the ALU add path for the T9/T10 processor datapath.
- Start/busy/done handshake toward the processor control unit.
- Operand and result width = 4*N_NIB.

Parameters:
N_NIB, 4, number of nibbles processed; operand width W = 4*N_NIB (default 16)

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in state OCIOSO
sub  in  1  0 = A+B, 1 = A-B; sampled with start
a  in  W  operand A; sampled with start
b  in  W  operand B; sampled with start
busy  out  1  high while state = SOMA
done  out  1  one-cycle pulse; result/flags valid
result  out  W  sum/difference; held until next accepted start
carry_out  out  1  final carry; for sub, 1 = no borrow
overflow  out  1  two's-complement signed overflow

Behaviour:
- Reset values, asynchronous on rst=1:
  - state = OCIOSO; busy = 0; done = 0; result = 0; carry_out = 0; overflow = 0.
  - Internal operand registers, carry register and nibble index idx are cleared.
- FSM states: OCIOSO, SOMA, FIM. busy and done are Moore outputs: busy = (state==SOMA), done = (state==FIM).
- OCIOSO, start=1 at edge k:
  - Latch ra = a and rb = sub ? ~b : b.
  - Carry register c = sub; idx = 0; latch sub.
  - Clear result, carry_out and overflow; go to SOMA.
- OCIOSO, start=0: stay in OCIOSO; all outputs hold.
- SOMA, each edge:
  - Slice computes {cn, s} = ra[idx] + rb[idx] + c, where ra[idx]/rb[idx] are nibbles 4*idx+3..4*idx.
  - result nibble idx <= s; c <= cn; idx <= idx+1.
- SOMA, edge with idx == N_NIB-1:
  - Write the last nibble and set carry_out = cn.
  - overflow = (ra[W-1] == rb[W-1]) && (s[3] != ra[W-1]); go to FIM.
- Latency: start sampled at edge k.
  - Nibbles written at edges k+1 .. k+N_NIB.
  - done high in the cycle after edge k+N_NIB (4 cycles busy, 1 cycle done at default N_NIB).
- FIM: one cycle, then unconditionally go to OCIOSO. start during FIM is ignored; there is no back-to-back accept.
- start while busy (SOMA) is ignored. a, b and sub may change freely after acceptance without affecting the operation.
- Width rules:
  - Carry propagates only through the registered c between nibbles.
  - Arithmetic is modulo 2^W; no saturation.
- Subtraction is A + ~B + 1. carry_out=1 means A >= B (unsigned).
- rst asserted mid-operation: immediate return to OCIOSO with reset values. The partial result is discarded and no done is issued.
- result changes only in SOMA. Between operations it holds the last complete value, or 0 after reset.

Decomposition:
- Shared package holds:
  - State encoding constants OCIOSO=2'd0, SOMA=2'd1, FIM=2'd2.
  - Nibble width constant NIB_W=4.
- One combinational sub-module soma4_cin: 4-bit ripple adder with carry-in.
  - Ports: a[3:0], b[3:0], c_in, out[3:0], c_out.
  - Built from four 1-bit full adders, with c_in driving the bit-0 carry.
- The controller instantiates exactly one soma4_cin. Nibble selection and carry register are in the controller.

Test Plan:
- Add with nibble carry chain: a=0x1234, b=0x0FCD, sub=0 -> result 0x2201, carry_out=0, overflow=0; done exactly 5 cycles after the start edge; busy high for 4 cycles.
- Unsigned wrap: a=0xFFFF, b=0x0001, sub=0 -> result 0x0000, carry_out=1, overflow=0. Signed overflow: a=0x7FFF, b=0x0001 -> 0x8000, carry_out=0, overflow=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> result 0xFFFE, carry_out=0, overflow=0. Signed overflow: a=0x8000, b=0x0001, sub=1 -> 0x7FFF, carry_out=1, overflow=1.
- Handshake:
  - Hold start=1 continuously with changing a/b from the second cycle on. Only the first operands are used.
  - Operations are accepted only in OCIOSO, one per 6 cycles.
  - done is exactly one cycle wide.
- Reset mid-op: assert rst two cycles after start with a=0x1234, b=0x0FCD. Outputs go 0 immediately (asynchronously) and no done appears.
- After reset mid-op, a fresh start with a=0x0001, b=0x0002 completes normally with result 0x0003.

Source files
------------

// File: rtl/controle_soma16_pkg.sv
// Shared constants for the nibble-serial add/subtract controller.
package controle_soma16_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        SOMA   = 2'd1,
        FIM    = 2'd2
    } state_t;

endpackage

// File: rtl/controle_soma16_soma4_cin.sv
// 4-bit ripple-carry adder built from four full adders; c_in feeds bit 0.
module soma4_cin
    import controle_soma16_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             c_in,
    output logic [NIB_W-1:0] out,
    output logic             c_out
);

    logic [NIB_W:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign out[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[NIB_W];

endmodule

// File: rtl/controle_soma16.sv
// Sequences one 4-bit adder slice over N_NIB nibbles, LSB first, to add or
// subtract W-bit operands. Handshake: start is taken only when idle (busy=0,
// done=0); done pulses one cycle when result/carry_out/overflow are final.
module controle_soma16
    import controle_soma16_pkg::*;
#(
    parameter int N_NIB = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [NIB_W*N_NIB-1:0] a,
    input  logic [NIB_W*N_NIB-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [NIB_W*N_NIB-1:0] result,
    output logic                   carry_out,
    output logic                   overflow
);

    localparam int W     = NIB_W * N_NIB;
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

    state_t             state;
    logic [W-1:0]       ra;
    logic [W-1:0]       rb;
    logic               c;
    logic [IDX_W-1:0]   idx;

    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [NIB_W-1:0]   s;
    logic               cn;

    assign nib_a = ra[int'(idx)*NIB_W +: NIB_W];
    assign nib_b = rb[int'(idx)*NIB_W +: NIB_W];

    soma4_cin u_slice (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (c),
        .out   (s),
        .c_out (cn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OCIOSO;
            ra        <= '0;
            rb        <= '0;
            c         <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                OCIOSO: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B now, seed carry with sub.
                        ra        <= a;
                        rb        <= sub ? ~b : b;
                        c         <= sub;
                        idx       <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SOMA;
                    end
                end
                SOMA: begin
                    result[int'(idx)*NIB_W +: NIB_W] <= s;
                    c <= cn;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        carry_out <= cn;
                        overflow  <= (ra[W-1] == rb[W-1]) && (s[NIB_W-1] != ra[W-1]);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIM;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIM: begin
                    done  <= 1'b0;
                    state <= OCIOSO;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= OCIOSO;
                end
            endcase
        end
    end

endmodule
